// File: rtl/reg_dump_sequencer.sv
// Walks the register file and streams each register as an uppercase ASCII hex line.
// Define REG_DUMP_INDEX_EN to prefix every line with "II: " (register index, 2 hex chars).
module reg_dump_sequencer #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [31:0]       rf_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

`ifdef REG_DUMP_INDEX_EN
  localparam logic [3:0] LineLen = 4'd14;
`else
  localparam logic [3:0] LineLen = 4'd10;
`endif
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StSend, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [3:0]          pos_q, pos_d;
  logic [31:0]         value_q, value_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;

  logic [31:0]         char_src;
  logic [3:0]          char_pos;
  logic [2:0]          nib_sel;
  logic [7:0]          char_out;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? {4'h3, nib} : 8'h37 + {4'h0, nib};
  endfunction

  // The byte loaded into tx_data is the one after the current position, except in
  // LATCH where the first byte is built straight from rf_data.
  assign char_src = (state_q == StLatch) ? rf_data : value_q;
  assign char_pos = (state_q == StLatch) ? 4'd0 : pos_q + 4'd1;

`ifdef REG_DUMP_INDEX_EN
  logic [7:0] idx8;
  always_comb begin
    idx8     = 8'(idx_q);
    nib_sel  = 3'(char_pos - 4'd4);
    char_out = 8'h0A;
    if (char_pos == 4'd0)       char_out = hex_char(idx8[7:4]);
    else if (char_pos == 4'd1)  char_out = hex_char(idx8[3:0]);
    else if (char_pos == 4'd2)  char_out = 8'h3A;
    else if (char_pos == 4'd3)  char_out = 8'h20;
    else if (char_pos < 4'd12)  char_out = hex_char(char_src[{3'd7 - nib_sel, 2'b00} +: 4]);
    else if (char_pos == 4'd12) char_out = 8'h0D;
  end
`else
  always_comb begin
    nib_sel  = char_pos[2:0];
    char_out = 8'h0A;
    if (char_pos < 4'd8)       char_out = hex_char(char_src[{3'd7 - nib_sel, 2'b00} +: 4]);
    else if (char_pos == 4'd8) char_out = 8'h0D;
  end
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pos_d      = pos_q;
    value_d    = value_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          idx_d   = '0;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        value_d    = rf_data;
        pos_d      = '0;
        tx_valid_d = 1'b1;
        tx_data_d  = char_out;
        state_d    = StSend;
      end
      StSend: begin
        if (tx_ready) begin
          if (pos_q == LineLen - 4'd1) begin
            tx_valid_d = 1'b0;
            if (idx_q == LastIdx) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = StFetch;
            end
          end else begin
            pos_d     = pos_q + 4'd1;
            tx_data_d = char_out;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      pos_q      <= '0;
      value_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pos_q      <= pos_d;
      value_q    <= value_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign busy     = (state_q == StFetch) || (state_q == StLatch) || (state_q == StSend);
  assign done     = (state_q == StDone);
  assign rf_addr  = idx_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Scoreboard bench for reg_dump_sequencer: expected bytes queued per dump, popped on acceptance.
module tb_reg_dump_sequencer;
`ifdef REG_DUMP_INDEX_EN
  localparam int NREGS = 12;
  localparam int LLEN  = 14;
`else
  localparam int NREGS = 4;
  localparam int LLEN  = 10;
`endif
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, start, tx_ready;
  logic          busy, done, tx_valid;
  logic [AW-1:0] rf_addr;
  logic [31:0]   rf_data;
  logic [7:0]    tx_data;
  logic [31:0]   rf_mem [0:31];

  byte unsigned expq[$];
  byte unsigned rx[$];
  int errors = 0;
  int checks = 0;
  string hx = "0123456789ABCDEF";

  assign rf_data = rf_mem[rf_addr];
  always #5 clk = ~clk;

  reg_dump_sequencer #(.NUM_REGS(NREGS), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rf_addr(rf_addr), .rf_data(rf_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  task automatic push_dump();
    logic [31:0] v;
    for (int r = 0; r < NREGS; r++) begin
      v = rf_mem[r];
`ifdef REG_DUMP_INDEX_EN
      expq.push_back(hx[(r >> 4) & 15]);
      expq.push_back(hx[r & 15]);
      expq.push_back(8'h3A);
      expq.push_back(8'h20);
`endif
      for (int k = 7; k >= 0; k--) expq.push_back(hx[(v >> (4 * k)) & 15]);
      expq.push_back(8'h0D);
      expq.push_back(8'h0A);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Runs until done is seen; returns bytes accepted and cycles from last acceptance to done.
  task automatic drain(input int pct, input bit spam, output int got, output int gap);
    int last_acc;
    bit stall, seen;
    byte unsigned held, want;
    got = 0; gap = -1; last_acc = 0; stall = 0; seen = 0; held = 0;
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      @(negedge clk);
      if (stall) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== held) begin
          errors++;
          $display("FAIL stall_hold: tx_valid=%b tx_data=%h, required 1 / %h", tx_valid, tx_data, held);
        end
      end
      if (done === 1'b1) begin
        seen = 1; gap = cyc - last_acc; tx_ready = 1'b0; start = 1'b0;
      end else begin
        start    = spam && busy && ($urandom_range(2) == 0);
        tx_ready = ($urandom_range(99) < pct);
        stall    = tx_valid && !tx_ready;
        held     = tx_data;
        if (tx_valid && tx_ready) begin
          got++; last_acc = cyc; rx.push_back(tx_data); checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL extra_byte: got %h, required no byte", tx_data);
          end else begin
            want = expq.pop_front();
            if (tx_data !== want) begin
              errors++;
              $display("FAIL byte[%0d]: got %h, required %h", got - 1, tx_data, want);
            end
          end
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within budget, required done");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks += 5;
    if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (done !== 1'b0)     begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", tx_valid); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h, required 00", tx_data); end
    if (rf_addr !== '0)    begin errors++; $display("FAIL rst_addr: got %0d, required 0", rf_addr); end
  endtask

  task automatic test_basic();
    int got, gap, bad;
    string line = "12345678\r\n";
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h12345678;
    expq.delete(); rx.delete(); push_dump();
    pulse_start();
    checks += 3;
    if (busy !== 1'b1)     begin errors++; $display("FAIL start_busy: got %b, required 1", busy); end
    if (rf_addr !== '0)    begin errors++; $display("FAIL start_addr: got %0d, required 0", rf_addr); end
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL early_valid: got %b, required 0", tx_valid); end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL latch_valid: got %b, required 0", tx_valid); end
    drain(100, 1'b0, got, gap);
    checks += 4;
    if (got != NREGS * LLEN) begin errors++; $display("FAIL basic_count: got %0d, required %0d", got, NREGS * LLEN); end
    if (gap != 1)            begin errors++; $display("FAIL done_gap: got %0d, required 1", gap); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL done_busy: got %b, required 0", busy); end
    if (expq.size() != 0)    begin errors++; $display("FAIL basic_left: got %0d, required 0", expq.size()); end
`ifndef REG_DUMP_INDEX_EN
    bad = 0;
    for (int i = 0; i < rx.size(); i++) if (rx[i] != line[i % 10]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL basic_text: got %0d wrong bytes, required 0", bad); end
`endif
  endtask

  task automatic test_hex();
    int got, gap, bad;
`ifdef REG_DUMP_INDEX_EN
    string ref_s = "0A: 0000ABCD\r\n";
    int base = 10 * 14;
`else
    string ref_s = "DEADBEEF\r\n00000000\r\n";
    int base = 0;
`endif
    rf_mem[0] = 32'hDEADBEEF; rf_mem[1] = 32'h0; rf_mem[2] = 32'h9ABCDEF0;
    rf_mem[3] = 32'h0F1E2D3C; rf_mem[10] = 32'h0000ABCD;
    expq.delete(); rx.delete(); push_dump();
    pulse_start();
    drain(100, 1'b0, got, gap);
    bad = 0;
    for (int i = 0; i < ref_s.len(); i++)
      if (base + i >= rx.size() || rx[base + i] != ref_s[i]) bad++;
    checks += 2;
    if (bad != 0) begin errors++; $display("FAIL hex_text: got %0d wrong bytes, required 0", bad); end
    if (got != NREGS * LLEN) begin errors++; $display("FAIL hex_count: got %0d, required %0d", got, NREGS * LLEN); end
  endtask

  task automatic test_backpressure();
    int got, gap;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    expq.delete(); rx.delete(); push_dump();
    pulse_start();
    drain(30, 1'b0, got, gap);
    checks += 2;
    if (got != NREGS * LLEN) begin errors++; $display("FAIL bp_count: got %0d, required %0d", got, NREGS * LLEN); end
    if (expq.size() != 0)    begin errors++; $display("FAIL bp_left: got %0d, required 0", expq.size()); end
  endtask

  task automatic test_start_spam();
    int got, gap, stray;
    expq.delete(); rx.delete(); push_dump();
    pulse_start();
    drain(70, 1'b1, got, gap);
    start = 1'b1;            // DONE cycle: must be ignored
    @(negedge clk) start = 1'b0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0 || done !== 1'b0) stray++;
      @(negedge clk);
    end
    checks += 2;
    if (got != NREGS * LLEN) begin errors++; $display("FAIL spam_count: got %0d, required %0d", got, NREGS * LLEN); end
    if (stray != 0) begin errors++; $display("FAIL spam_restart: got %0d busy/done cycles, required 0", stray); end
  endtask

  task automatic test_back_to_back();
    int got, gap;
    expq.delete(); rx.delete(); push_dump();
    pulse_start();
    drain(100, 1'b0, got, gap);
    @(negedge clk);          // IDLE re-entered this cycle
    start = 1'b1;
    expq.delete(); push_dump();
    @(negedge clk) start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b, required 1", busy); end
    drain(100, 1'b0, got, gap);
    checks++;
    if (got != NREGS * LLEN) begin errors++; $display("FAIL b2b_count: got %0d, required %0d", got, NREGS * LLEN); end
  endtask

  task automatic test_reset_mid();
    int got, gap, target, stray;
    bit reached;
    byte unsigned want;
    expq.delete(); rx.delete(); push_dump();
    pulse_start();
    target = 2 * LLEN + 4;
    got = 0; reached = 0;
    for (int cyc = 0; cyc < 300 && !reached; cyc++) begin
      @(negedge clk);
      if (tx_valid && got == target) begin
        reached = 1; tx_ready = 1'b0;
      end else begin
        tx_ready = 1'b1;
        if (tx_valid) begin got++; void'(expq.pop_front()); end
      end
    end
    checks += 3;
    if (!reached) begin errors++; $display("FAIL mid_reach: got %0d bytes, required %0d", got, target); end
    want = (expq.size() > 0) ? expq[0] : 8'h00;
    if (tx_data !== want) begin errors++; $display("FAIL mid_byte: got %h, required %h", tx_data, want); end
    if (rf_addr !== AW'(2)) begin errors++; $display("FAIL mid_addr: got %0d, required 2", rf_addr); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    checks += 4;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b, required 0", tx_valid); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy: got %b, required 0", busy); end
    if (rf_addr !== '0)    begin errors++; $display("FAIL mid_raddr: got %0d, required 0", rf_addr); end
    if (done !== 1'b0)     begin errors++; $display("FAIL mid_done: got %b, required 0", done); end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || tx_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL mid_stray: got %0d cycles, required 0", stray); end
    expq.delete(); rx.delete(); push_dump();
    pulse_start();
    drain(100, 1'b0, got, gap);
    checks++;
    if (got != NREGS * LLEN) begin errors++; $display("FAIL mid_redump: got %0d, required %0d", got, NREGS * LLEN); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    test_reset();
    test_basic();
    test_hex();
    test_backpressure();
    test_start_spam();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
